// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit engine draining the TX byte FIFO.
// Frame: 1 start bit, DWIDTH data bits LSB first, optional even parity, 1 stop bit.
// Define UART_TX_PARITY_EN to include the PARITY state (8E1); default build is 8N1.
// The FIFO read port has a one-cycle registered latency, which is why the
// FETCH and LOAD states are separate.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DWIDTH       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state;
    logic [CW-1:0]     baud_cnt;
    logic [IW-1:0]     bit_idx;
    logic [DWIDTH-1:0] shift;
    logic              baud_wrap;
`ifdef UART_TX_PARITY_EN
    logic              parity;
`endif

    // Bit boundary: the last cycle of the current bit period.
    always_comb begin
        baud_wrap = (baud_cnt == BAUD_LAST);
    end

    // FIFO read strobe is a pure decode of the FETCH state.
    always_comb begin
        fifo_rd_en = (state == FETCH);
    end

    // Frame sequencer; tx, busy and tx_done are registered alongside the state.
    // tx is loaded with the next bit's level on the wrap cycle, so each level
    // change lands exactly on a bit boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    if (tx_en && !fifo_empty) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end

                FETCH: begin
                    state <= LOAD;
                end

                LOAD: begin
                    shift    <= fifo_rdata;
                    bit_idx  <= '0;
                    baud_cnt <= '0;
                    tx       <= 1'b0;
                    state    <= START;
`ifdef UART_TX_PARITY_EN
                    parity   <= 1'b0;
`endif
                end

                START: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
`ifdef UART_TX_PARITY_EN
                        parity   <= parity ^ shift[0];
`endif
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            tx      <= parity ^ shift[0];
                            state   <= PARITY;
`else
                            tx      <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
`endif

                STOP: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tx_done  <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: behavioural FIFO, scoreboard of expected
// frames, and a line monitor that decodes tx independently of the stimulus.
// Honours UART_TX_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    localparam int C  = 4;
    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tx_en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          tx_done;

    uart_tx_serializer #(.CLKS_PER_BIT(C), .DWIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            start;   // absolute cycle of first start-bit cycle, -1 = don't care
        int            gap;     // cycles from previous stop-bit start to this start, -1 = don't care
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] burst[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int rd_count   = 0;
    int last_rd    = -1;

    logic          in_frame  = 1'b0;
    int            k         = 0;
    int            fstart    = 0;
    int            last_stop = 0;
    logic          bad       = 1'b0;
    logic          bad_lvl   = 1'b0;
    logic [NB-1:0] ebits     = '0;
    exp_t          cur;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: registered read data, one cycle after readEn.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
    end
    always @(negedge clk) fifo_empty <= (fifo_q.size() == 0);

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected line levels for one frame, bit by bit.
    function automatic logic [NB-1:0] frame_bits(input logic [DW-1:0] d);
        logic [NB-1:0] b;
        b = '0;
        b[0] = 1'b0;
        for (int i = 0; i < DW; i++) b[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        b[DW+1] = ^d;
`endif
        b[NB-1] = 1'b1;
        return b;
    endfunction

    // Monitor: decodes the line, compares against the scoreboard head.
    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1) begin
            rd_count++;
            last_rd = cyc;
            if (fifo_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL rd_while_empty: fifo_rd_en=1 at cycle %0d, required 0", cyc);
            end
        end
        if (!reset) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required none", cyc);
                    cur = '{data: '0, start: -1, gap: -1};
                end else begin
                    cur = sb.pop_front();
                end
                ebits    = frame_bits(cur.data);
                in_frame = 1'b1;
                k        = 0;
                bad      = 1'b0;
                fstart   = cyc;
                if (cur.start >= 0) check("start_cycle", cyc, cur.start);
                if (cur.gap >= 0) check("interframe_gap", cyc - last_stop, cur.gap);
            end
            if (in_frame) begin
                if (k < NB * C) begin
                    if (tx !== ebits[k / C] || busy !== 1'b1 || tx_done !== 1'b0) begin
                        bad     = 1'b1;
                        bad_lvl = tx;
                    end
                    if (k % C == C - 1) begin
                        compared++;
                        if (bad) begin
                            mismatched++;
                            $display("FAIL frame_bit: byte 0x%02h bit %0d tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                                     cur.data, k / C, bad_lvl, busy, tx_done, ebits[k / C]);
                        end
                        bad = 1'b0;
                    end
                    k++;
                end else begin
                    check("done_busy_tx", int'({tx_done, busy, tx}), 5);
                    last_stop = fstart + (NB - 1) * C;
                    in_frame  = 1'b0;
                end
            end else if (tx_done !== 1'b0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_done: tx_done=%b at cycle %0d, required 0", tx_done, cyc);
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || in_frame || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", (n < budget) ? 1 : 0, 1);
    endtask

    // Enables the engine for bytes already sitting in the FIFO (listed in burst).
    task automatic kick();
        int t0;
        int rd0;
        repeat (2) @(negedge clk);
        t0 = cyc;
        foreach (burst[i])
            sb.push_back('{data: burst[i], start: (i == 0) ? t0 + 3 : -1, gap: (i == 0) ? -1 : C + 3});
        rd0   = rd_count;
        tx_en = 1'b1;
        wait_idle(burst.size() * (NB * C + 10) + 50);
        tx_en = 1'b0;
        check("rd_pulses", rd_count - rd0, burst.size());
        check("first_rd_cycle", last_rd - (burst.size() - 1) * (NB * C + 3), t0 + 1);
    endtask

    task automatic send_burst();
        foreach (burst[i]) fifo_q.push_back(burst[i]);
        kick();
    endtask

    initial begin
        int t0;
        int rd0;
        int anomalies;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(tx_done), 0);
        check("reset_rd_en", int'(fifo_rd_en), 0);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: rd_en at cycle 1, start at cycle 3, done at 3+NB*C
        burst.delete();
        burst.push_back(8'hA5);
        send_burst();

        // Empty FIFO with enable held
        rd0 = rd_count;
        anomalies = 0;
        tx_en = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1 || fifo_rd_en !== 1'b0) anomalies++;
        end
        tx_en = 1'b0;
        check("empty_rd_pulses", rd_count - rd0, 0);
        check("empty_anomalies", anomalies, 0);

        // Back-to-back
        burst.delete();
        burst.push_back(8'h00);
        burst.push_back(8'hFF);
        burst.push_back(8'h3C);
        send_burst();

        // Parity-relevant bytes
        burst.delete();
        burst.push_back(8'h07);
        burst.push_back(8'h03);
        send_burst();

        // Enable drop mid-frame: second byte must stay in the FIFO
        fifo_q.push_back(8'h81);
        fifo_q.push_back(8'h42);
        repeat (2) @(negedge clk);
        t0 = cyc;
        sb.push_back('{data: 8'h81, start: t0 + 3, gap: -1});
        rd0 = rd_count;
        tx_en = 1'b1;
        repeat (3 + 3 * C) @(negedge clk);
        tx_en = 1'b0;
        wait_idle(NB * C + 50);
        repeat (30) @(negedge clk);
        check("drop_rd_pulses", rd_count - rd0, 1);
        check("drop_fifo_left", fifo_q.size(), 1);
        burst.delete();
        burst.push_back(8'h42);
        kick();

        // Reset during data bit 4 of 0x55
        fifo_q.push_back(8'h55);
        repeat (2) @(negedge clk);
        t0 = cyc;
        sb.push_back('{data: 8'h55, start: t0 + 3, gap: -1});
        tx_en = 1'b1;
        repeat (3 + 5 * C + 1) @(negedge clk);
        tx_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midrst_tx", int'(tx), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_rd_en", int'(fifo_rd_en), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        burst.delete();
        burst.push_back(8'hC3);
        send_burst();

        // Randomized bursts
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 4);
            burst.delete();
            for (int i = 0; i < n; i++) burst.push_back(DW'($urandom));
            send_burst();
            repeat ($urandom_range(1, 10)) @(negedge clk);
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
